// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one registered signed multiplier between NREQ requesters. Requests
//   are arbitrated round-robin and the winner's operands are steered onto the
//   multiplier inputs. A small tag pipe travels alongside the multiplier so
//   that every product leaves with the index of the requester that issued it.
//   A response that is presented but not accepted stalls everything (the
//   multiplier registers, the tag pipe and the round-robin pointer) by
//   dropping mul_en.
//
// Ports
//   clk         clock, all logic on posedge
//   reset       synchronous, active-high (also tie to the multiplier reset)
//   req_valid   per-requester request valid
//   req_ready   per-requester accept, one-hot or zero
//   req_a/req_b per-requester operands, requester i at [i*N +: N]
//   mul_en      enable for every multiplier register
//   mul_a/mul_b operands to the multiplier (zero when nothing is granted)
//   mul_result  registered product from the multiplier
//   rsp_valid   response valid
//   rsp_ready   response accept
//   rsp_id      requester index owning rsp_result
//   rsp_result  full-width signed product
//   busy        at least one operation in flight
module mult_share_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*N-1:0]        req_a,
    input  logic [NREQ*N-1:0]        req_b,
    output logic                     mul_en,
    output logic signed [N-1:0]      mul_a,
    output logic signed [N-1:0]      mul_b,
    input  logic signed [2*N-1:0]    mul_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic signed [2*N-1:0]    rsp_result,
    output logic                     busy
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] winner;
    logic            grant_any;
    int              idx;

    // Per-stage tag: valid is control (reset), id is data (not reset).
    logic            vld_p [LAT];
    logic [ID_W-1:0] id_p  [LAT];

    // An unaccepted response freezes the whole datapath.
    assign mul_en = !(rsp_valid && !rsp_ready);

    // Round-robin search starting at ptr, wrapping mod NREQ.
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (mul_en && !grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                winner    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (grant_any) begin
            req_ready[winner] = 1'b1;
            mul_a = $signed(req_a[int'(winner)*N +: N]);
            mul_b = $signed(req_b[int'(winner)*N +: N]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);
        end
    end

    // ---- stage p0 .. p(LAT-1): tag pipe mirrors the multiplier registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < LAT; s++) vld_p[s] <= 1'b0;
        end else if (mul_en) begin
            vld_p[0] <= grant_any;
            for (int s = 1; s < LAT; s++) vld_p[s] <= vld_p[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (mul_en) begin
            id_p[0] <= winner;
            for (int s = 1; s < LAT; s++) id_p[s] <= id_p[s-1];
        end
    end

    // ---- output: last tag stage lines up with the multiplier output reg ----
    assign rsp_valid  = vld_p[LAT-1];
    assign rsp_id     = id_p[LAT-1];
    assign rsp_result = mul_result;

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < LAT; s++) busy = busy | vld_p[s];
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int ID_W = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*N-1:0]     req_a = '0;
    logic [NREQ*N-1:0]     req_b = '0;
    logic                  mul_en;
    logic signed [N-1:0]   mul_a, mul_b;
    logic signed [2*N-1:0] mul_result;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [ID_W-1:0]       rsp_id;
    logic signed [2*N-1:0] rsp_result;
    logic                  busy;

    always #5 clk = ~clk;

    mult_share_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
    );

    // Two-register signed multiplier (input regs, output reg) with enable.
    logic signed [N-1:0]   m_a, m_b;
    logic signed [2*N-1:0] m_p;
    always_ff @(posedge clk) begin
        if (reset) begin
            m_a <= '0; m_b <= '0; m_p <= '0;
        end else if (mul_en) begin
            m_a <= mul_a; m_b <= mul_b;
            m_p <= 64'(m_a) * 64'(m_b);
        end
    end
    assign mul_result = m_p;

    // Reference model: ordered list of accepted ops with their age in
    // enabled edges since acceptance; the head is presented once age >= LAT.
    typedef struct {
        int          id;
        logic [63:0] prod;
        int          age;
    } op_t;
    op_t mq[$];
    int  mptr;

    logic signed [N-1:0] opa [NREQ];
    logic signed [N-1:0] opb [NREQ];
    logic                pend [NREQ];

    int          grant_log[$];
    int          rid_log[$];
    logic [63:0] rres_log[$];
    int          passed = 0;
    int          total  = 0;
    int          acc_cnt = 0;
    logic [63:0] obs_res;
    int          obs_id;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = pend[i];
            req_a[i*N +: N]    = opa[i];
            req_b[i*N +: N]    = opb[i];
        end
    endtask

    task automatic set_req(input int i, input logic signed [N-1:0] a, input logic signed [N-1:0] b);
        pend[i] = 1'b1; opa[i] = a; opb[i] = b;
    endtask

    task automatic clear_logs();
        grant_log.delete(); rid_log.delete(); rres_log.delete(); acc_cnt = 0;
    endtask

    // One clock cycle: drive, check at negedge against the model, advance
    // the model at posedge.
    task automatic cycle();
        int          g;
        logic        exp_v, en, hs;
        logic [NREQ-1:0] exp_rdy;
        op_t         op;
        apply();
        @(negedge clk);
        exp_v = (mq.size() > 0) && (mq[0].age >= LAT);
        en    = !(exp_v && !rsp_ready);
        g     = -1;
        if (en) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (mptr + k) % NREQ;
                if (g < 0 && pend[j]) g = j;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        chk("busy",      64'(busy),      64'(mq.size() > 0));
        chk("mul_en",    64'(mul_en),    64'(en));
        obs_res = rsp_result;
        obs_id  = int'(rsp_id);
        if (exp_v) begin
            chk("rsp_id",     64'(rsp_id), 64'(mq[0].id));
            chk("rsp_result", rsp_result,  mq[0].prod);
        end
        hs = exp_v && rsp_ready;
        if (hs) begin
            rid_log.push_back(int'(rsp_id));
            rres_log.push_back(rsp_result);
        end
        @(posedge clk);
        if (en) begin
            if (hs) void'(mq.pop_front());
            foreach (mq[i]) mq[i].age++;
            if (g >= 0) begin
                op.id   = g;
                op.prod = 64'(opa[g]) * 64'(opb[g]);
                op.age  = 1;
                mq.push_back(op);
                mptr = (g + 1) % NREQ;
                grant_log.push_back(g);
                acc_cnt++;
            end
        end
        #1;
        if (g >= 0) pend[g] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        apply();
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        mptr = 0;
        clear_logs();
    endtask

    task automatic run_until_rsp(input int n, input int budget);
        int c;
        c = 0;
        while (rid_log.size() < n && c < budget) begin
            cycle();
            c++;
        end
        chk("rsp_count", 64'(rid_log.size()), 64'(n));
    endtask

    task automatic drain(input string tag);
        int c;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        rsp_ready = 1'b1;
        c = 0;
        while (mq.size() > 0 && c < 40) begin
            cycle();
            c++;
        end
        chk(tag, 64'(mq.size()), 64'd0);
    endtask

    initial begin
        int c1, c3, n;
        logic [63:0] s_res;
        int          s_id;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; opa[i] = '0; opb[i] = '0;
        end
        mptr = 0;

        // Reset state
        do_reset();
        cycle();
        chk("reset_busy", 64'(busy), 64'd0);

        // 1: single request 3 * -5
        set_req(0, 32'sd3, -32'sd5);
        cycle();
        chk("t1_grant", 64'(grant_log[0]), 64'd0);
        n = 0;
        while (rid_log.size() == 0 && n < 10) begin
            cycle();
            n++;
        end
        chk("t1_latency", 64'(n), 64'(LAT));
        chk("t1_id", 64'(rid_log.size() > 0 ? rid_log[0] : -1), 64'd0);
        chk("t1_res", rres_log.size() > 0 ? rres_log[0] : 64'hx, 64'hFFFF_FFFF_FFFF_FFF1);

        // 2: all four at once, grants 0..3 and results 10..40
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 32'sd10);
        repeat (4) cycle();
        run_until_rsp(4, 20);
        for (int i = 0; i < 4; i++) begin
            chk("t2_grant", 64'(grant_log[i]), 64'(i));
            chk("t2_id",    64'(i < rid_log.size() ? rid_log[i] : -1), 64'(i));
            chk("t2_res",   i < rres_log.size() ? rres_log[i] : 64'hx, 64'(10 * (i + 1)));
        end

        // 3: requesters 1 and 3 always valid
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (!pend[1]) set_req(1, 32'($urandom), 32'($urandom));
            if (!pend[3]) set_req(3, 32'($urandom), 32'($urandom));
            cycle();
        end
        c1 = 0; c3 = 0;
        foreach (grant_log[i]) begin
            if (grant_log[i] == 1) c1++;
            if (grant_log[i] == 3) c3++;
        end
        chk("t3_first", 64'(grant_log[0]), 64'd1);
        chk("t3_alt",   64'(grant_log[1]), 64'd3);
        chk("t3_cnt1",  64'(c1), 64'd10);
        chk("t3_cnt3",  64'(c3), 64'd10);
        drain("t3_drain");

        // 4: full pipe then 3 stalled cycles
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i]) set_req(i, 32'($urandom), 32'($urandom));
            cycle();
        end
        rsp_ready = 1'b0;
        cycle();
        s_res = obs_res; s_id = obs_id;
        chk("t4_stall_en", 64'(mul_en), 64'd0);
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("t4_res_frozen", obs_res, s_res);
            chk("t4_id_frozen",  64'(obs_id), 64'(s_id));
            chk("t4_no_grant",   64'(req_ready), 64'd0);
        end
        drain("t4_drain");
        chk("t4_no_loss", 64'(rid_log.size()), 64'(acc_cnt));

        // 5: extreme operands
        clear_logs();
        set_req(2, 32'h8000_0000, 32'h8000_0000);
        run_until_rsp(1, 10);
        chk("t5_minmin", rres_log.size() > 0 ? rres_log[0] : 64'hx, 64'h4000_0000_0000_0000);
        set_req(2, 32'h8000_0000, 32'sd1);
        run_until_rsp(2, 10);
        chk("t5_minone", rres_log.size() > 1 ? rres_log[1] : 64'hx, 64'hFFFF_FFFF_8000_0000);

        // 6: reset with two ops in flight
        do_reset();
        set_req(1, 32'sd7, 32'sd7);
        set_req(2, 32'sd6, 32'sd6);
        cycle();
        cycle();
        do_reset();
        cycle();
        chk("t6_busy",  64'(busy), 64'd0);
        chk("t6_valid", 64'(rsp_valid), 64'd0);
        set_req(1, 32'sd2, 32'sd3);
        set_req(2, -32'sd9, 32'sd11);
        set_req(3, 32'sd4, 32'sd4);
        cycle();
        chk("t6_ptr0", 64'(grant_log[0]), 64'd1);
        run_until_rsp(3, 20);
        chk("t6_id2",  64'(rid_log.size() > 1 ? rid_log[1] : -1), 64'd2);
        chk("t6_res2", rres_log.size() > 1 ? rres_log[1] : 64'hx, 64'hFFFF_FFFF_FFFF_FF9D);

        // Random traffic with random backpressure
        do_reset();
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 32'($urandom), 32'($urandom));
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain("rand_drain");
        chk("rand_no_loss", 64'(rid_log.size()), 64'(acc_cnt));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
